// File: rtl/rv32i_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
package rv32i_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } imem_state_t;

endpackage

// File: rtl/rv32i_imem_array.sv
// Instruction storage: one shared address, synchronous write, registered read.
module rv32i_imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32i_imem_responder.sv
// Instruction memory for the fetch stage with a byte-serial boot loader.
// state | meaning
// RUN   | serve fetch reads, accept ld_start
// LOAD  | accept loader bytes, commit little-endian words, fetch sees NOP
// FLUSH | one idle cycle after the final byte before returning to RUN
module rv32i_imem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = rv32i_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] memIfAddr,
  output logic [31:0] memIfData,
  output logic        addr_err,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_ovf
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  imem_state_t state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [23:0] asm_q, asm_d;
  logic        ovf_q, ovf_d;
  logic        nop_q, err_q;

  logic        accept, commit, full, oor, ram_we;
  logic [31:0] word_w, ram_rdata;
  logic [AW-1:0] ram_addr;

  assign accept = (state_q == LOAD) && ld_valid;
  assign commit = accept && ((lane_q == 2'd3) || ld_last);
  // wptr saturates at DEPTH_WORDS, which is exactly when its top bit is set
  assign full   = wptr_q[AW];
  assign ram_we = commit && !full;
  assign oor    = ({2'b00, memIfAddr} >= DEPTH_WORDS);

  always_comb begin
    word_w = {8'h00, asm_q};
    case (lane_q)
      2'd0:    word_w[7:0]   = ld_byte;
      2'd1:    word_w[15:8]  = ld_byte;
      2'd2:    word_w[23:16] = ld_byte;
      default: word_w[31:24] = ld_byte;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    wptr_d  = wptr_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        if (ld_start) begin
          state_d = LOAD;
          lane_d  = 2'd0;
          wptr_d  = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (commit) begin
          lane_d = 2'd0;
          asm_d  = '0;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end else if (accept) begin
          lane_d = lane_q + 2'd1;
          asm_d  = word_w[23:0];
        end
        if (accept && ld_last) begin
          state_d = FLUSH;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign ram_addr = (state_q == LOAD) ? wptr_q[AW-1:0] : memIfAddr[AW-1:0];

  rv32i_imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(word_w),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      lane_q  <= 2'd0;
      wptr_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      nop_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      wptr_q  <= wptr_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      nop_q   <= (state_q != RUN) || oor;
      err_q   <= (state_q == RUN) && oor;
    end
  end

  // Read data is registered in the array; the NOP select is registered alongside it
  assign memIfData = nop_q ? NOP_WORD : ram_rdata;
  assign addr_err  = err_q;
  assign ld_ready  = (state_q == LOAD);
  assign ld_busy   = (state_q != RUN);
  assign ld_ovf    = ovf_q;

endmodule

// File: tb/tb_rv32i_imem_responder.sv
// Scoreboarded bench: a 1024-word and a 4-word responder against a word-level memory model.
module tb_rv32i_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic [29:0] addr [2];
  logic [31:0] data [2];
  logic        err  [2];
  logic        st   [2];
  logic        vld  [2];
  logic [7:0]  byt  [2];
  logic        lst  [2];
  logic        rdy  [2];
  logic        bsy  [2];
  logic        ovf  [2];

  rv32i_imem_responder #(.DEPTH_WORDS(1024)) u_dut0 (
    .clk(clk), .reset(rst[0]), .memIfAddr(addr[0]), .memIfData(data[0]), .addr_err(err[0]),
    .ld_start(st[0]), .ld_valid(vld[0]), .ld_byte(byt[0]), .ld_last(lst[0]),
    .ld_ready(rdy[0]), .ld_busy(bsy[0]), .ld_ovf(ovf[0]));

  rv32i_imem_responder #(.DEPTH_WORDS(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .memIfAddr(addr[1]), .memIfData(data[1]), .addr_err(err[1]),
    .ld_start(st[1]), .ld_valid(vld[1]), .ld_byte(byt[1]), .ld_last(lst[1]),
    .ld_ready(rdy[1]), .ld_busy(bsy[1]), .ld_ovf(ovf[1]));

  int cycle = 0;
  always @(posedge clk) cycle++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          sel;
    int          cyc;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mm [2][1024];
  bit          kn [2][1024];
  int          dep [2] = '{1024, 4};

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
      e = exp_q.pop_front();
      check($sformatf("fetch%0d_data", e.sel), data[e.sel], e.d);
      check($sformatf("fetch%0d_err", e.sel), {31'd0, err[e.sel]}, {31'd0, e.e});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(int sel, logic [31:0] d, logic e);
    exp_q.push_back('{sel, cycle + 1, d, e});
  endtask

  task automatic fetch(int sel, logic [29:0] a);
    addr[sel] = a;
    if ({2'b00, a} >= 32'(dep[sel])) expect_next(sel, NOP, 1'b1);
    else expect_next(sel, mm[sel][a[9:0]], 1'b0);
    tick();
  endtask

  task automatic fetch_const(int sel, logic [29:0] a, logic [31:0] d, logic e);
    addr[sel] = a;
    tick();
    check($sformatf("const%0d_data@%0d", sel, a), data[sel], d);
    check($sformatf("const%0d_err@%0d", sel, a), {31'd0, err[sel]}, {31'd0, e});
  endtask

  task automatic fetch_rand(int sel);
    logic [29:0] a;
    int r, k;
    r = $urandom_range(0, 3);
    if (r == 0) a = 30'(dep[sel]) + 30'($urandom_range(0, 1000));
    else if (r == 1) a = 30'($urandom) | 30'h2000_0000;
    else begin
      a = 30'(dep[sel]);
      for (int t = 0; t < 32; t++) begin
        k = $urandom_range(0, dep[sel] - 1);
        if (kn[sel][k]) begin
          a = 30'(k);
          break;
        end
      end
    end
    fetch(sel, a);
  endtask

  // Fetch during LOAD/FLUSH/reset: any address must return NOP with no error
  task automatic busy_tick(int sel);
    addr[sel] = 30'($urandom);
    expect_next(sel, NOP, 1'b0);
    tick();
  endtask

  // rst_after < 0: ld_last on the final byte; otherwise reset after all bytes of b
  task automatic do_load(int sel, input logic [7:0] b[$], int rst_after);
    int n, limit;
    logic [31:0] w;
    n = b.size();
    st[sel]   = 1'b1;
    addr[sel] = 30'h3FFF_FFFF;
    expect_next(sel, NOP, 1'b1);
    tick();
    st[sel] = 1'b0;
    check("load_busy", {31'd0, bsy[sel]}, 32'd1);
    check("load_ready", {31'd0, rdy[sel]}, 32'd1);
    check("ovf_cleared", {31'd0, ovf[sel]}, 32'd0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        vld[sel] = 1'b0;
        byt[sel] = 8'($urandom);
        lst[sel] = 1'($urandom);
        st[sel]  = 1'($urandom);
        busy_tick(sel);
      end
      vld[sel] = 1'b1;
      byt[sel] = b[i];
      lst[sel] = (rst_after < 0) && (i == n - 1);
      st[sel]  = 1'($urandom);
      busy_tick(sel);
    end
    vld[sel] = 1'b0;
    lst[sel] = 1'b0;
    st[sel]  = 1'b0;
    if (rst_after >= 0) begin
      rst[sel] = 1'b1;
      busy_tick(sel);
      rst[sel] = 1'b0;
      check("rst_ready", {31'd0, rdy[sel]}, 32'd0);
      check("rst_busy", {31'd0, bsy[sel]}, 32'd0);
      limit = (n / 4) * 4;
    end else begin
      check("flush_busy", {31'd0, bsy[sel]}, 32'd1);
      check("flush_ready", {31'd0, rdy[sel]}, 32'd0);
      busy_tick(sel);
      check("run_busy", {31'd0, bsy[sel]}, 32'd0);
      check("ovf", {31'd0, ovf[sel]}, {31'd0, n > dep[sel] * 4});
      limit = n;
    end
    for (int wi = 0; wi * 4 < limit; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (wi * 4 + k < limit) w[k*8 +: 8] = b[wi*4 + k];
      if (wi < dep[sel]) begin
        mm[sel][wi] = w;
        kn[sel][wi] = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b[$];
    int sel, n;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; addr[s] = '0; st[s] = 1'b0; vld[s] = 1'b0;
      byt[s] = '0; lst[s] = 1'b0;
    end
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      check("reset_data", data[s], NOP);
      check("reset_err", {31'd0, err[s]}, 32'd0);
      check("reset_ready", {31'd0, rdy[s]}, 32'd0);
      check("reset_busy", {31'd0, bsy[s]}, 32'd0);
      check("reset_ovf", {31'd0, ovf[s]}, 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    b = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    do_load(0, b, -1);
    fetch_const(0, 30'd0, 32'h0050_0093, 1'b0);
    fetch_const(0, 30'd1, 32'h0010_0513, 1'b0);
    fetch(0, 30'd0);
    fetch(0, 30'd1);

    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    do_load(0, b, -1);
    fetch_const(0, 30'd0, 32'h0403_0201, 1'b0);
    fetch_const(0, 30'd1, 32'h0000_00AA, 1'b0);

    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load(0, b, 6);
    vld[0] = 1'b1;
    lst[0] = 1'b1;
    byt[0] = 8'hEE;
    fetch(0, 30'd1);
    fetch(0, 30'd0);
    vld[0] = 1'b0;
    lst[0] = 1'b0;
    fetch_const(0, 30'd0, 32'h4433_2211, 1'b0);
    fetch_const(0, 30'd1, 32'h0000_00AA, 1'b0);

    b = {};
    for (int i = 0; i < 4096; i++) b.push_back(8'($urandom));
    do_load(0, b, -1);
    fetch_const(0, 30'd1024, NOP, 1'b1);
    fetch(0, 30'd1023);
    fetch(0, 30'd1024);
    fetch(0, 30'h3FFF_FC00);

    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'(i + 1));
    do_load(1, b, -1);
    fetch_const(1, 30'd0, 32'h0403_0201, 1'b0);
    fetch_const(1, 30'd3, 32'h100F_0E0D, 1'b0);
    fetch_const(1, 30'd4, NOP, 1'b1);
    b = '{8'hC0, 8'hDE};
    do_load(1, b, -1);
    fetch_const(1, 30'd0, 32'h0000_DEC0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 1);
      n = $urandom_range(1, sel ? 24 : 40);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      do_load(sel, b, ($urandom_range(0, 5) == 0) ? n : -1);
      for (int f = 0; f < 8; f++) fetch_rand(sel);
    end

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
